// File: rtl/qoa_encoder.sv
// qoa_encoder: byte-fed QOA slice encoder.
// Runs the same 4-tap LMS predictor as the on-chip decoder. Each input sample
// is quantized to a 3-bit residual index. Predictor history and weights are
// updated exactly as the decoder updates them, so the two stay in lockstep.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst     in   asynchronous active-high reset
//   data_rdy    in   one-cycle strobe, spi_in valid
//   spi_in      in   [7:0] command / data byte
//   code_out    out  [7:0] last code byte {sf[3:0], qr[2:0], 1'b1}
//   code_valid  out  one-cycle pulse when code_out / recon_out update
//   recon_out   out  [15:0] last reconstructed sample
//   busy        out  high during PREDICT, QUANT and UPDATE
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | wait for a command byte
// LOAD_HI | write high byte of the selected history/weight register
// LOAD_LO | write low byte, then return to IDLE
// SAMP_HI | capture sample high byte
// SAMP_LO | capture sample low byte, clear accumulator
// PREDICT | 4 cycles, one history*weight product per cycle
// QUANT   | residual -> scaled, rounded, clamped -> 3-bit index
// UPDATE  | dequantize, reconstruct, adapt weights, shift history, emit

// Dequantization ROM shared with the decoder: scalefactor x residual index.
module QOA_ROM (
    input  logic        [3:0]  addr1,
    input  logic        [2:0]  addr2,
    output logic signed [15:0] data
);
    logic [63:0] row;
    logic [15:0] mag;

    always_comb begin
        row = 64'd0;
        case (addr1)
            4'd0:  row = {16'd1,    16'd3,    16'd5,    16'd7};
            4'd1:  row = {16'd5,    16'd18,   16'd32,   16'd49};
            4'd2:  row = {16'd16,   16'd53,   16'd95,   16'd147};
            4'd3:  row = {16'd34,   16'd113,  16'd203,  16'd315};
            4'd4:  row = {16'd63,   16'd210,  16'd378,  16'd588};
            4'd5:  row = {16'd104,  16'd345,  16'd621,  16'd966};
            4'd6:  row = {16'd158,  16'd528,  16'd950,  16'd1477};
            4'd7:  row = {16'd228,  16'd760,  16'd1368, 16'd2128};
            4'd8:  row = {16'd316,  16'd1053, 16'd1895, 16'd2947};
            4'd9:  row = {16'd422,  16'd1405, 16'd2529, 16'd3934};
            4'd10: row = {16'd548,  16'd1828, 16'd3290, 16'd5117};
            4'd11: row = {16'd696,  16'd2320, 16'd4176, 16'd6496};
            4'd12: row = {16'd868,  16'd2893, 16'd5207, 16'd8099};
            4'd13: row = {16'd1064, 16'd3548, 16'd6386, 16'd9933};
            4'd14: row = {16'd1286, 16'd4288, 16'd7718, 16'd12005};
            default: row = {16'd1536, 16'd5120, 16'd9216, 16'd14336};
        endcase
        case (addr2[2:1])
            2'd0:    mag = row[63:48];
            2'd1:    mag = row[47:32];
            2'd2:    mag = row[31:16];
            default: mag = row[15:0];
        endcase
        // Odd residual indices are the negative half of each pair.
        data = addr2[0] ? -$signed(mag) : $signed(mag);
    end
endmodule

module qoa_encoder (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        data_rdy,
    input  logic [7:0]  spi_in,
    output logic [7:0]  code_out,
    output logic        code_valid,
    output logic [15:0] recon_out,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, LOAD_HI, LOAD_LO, SAMP_HI, SAMP_LO, PREDICT, QUANT, UPDATE
    } state_t;

    state_t             state_q;
    logic        [3:0]  sf_q;
    logic               sel_q;
    logic        [1:0]  idx_q;
    logic signed [15:0] sample_q;
    logic signed [31:0] acc_q;
    logic        [1:0]  cnt_q;
    logic signed [15:0] p_q;
    logic        [2:0]  qr_q;
    logic signed [15:0] hist_q    [4];
    logic signed [15:0] weights_q [4];
    logic        [7:0]  code_q;
    logic               valid_q;
    logic        [15:0] recon_q;
    logic               busy_q;

    logic signed [31:0] mac_prod;
    logic signed [15:0] p_d;
    logic signed [16:0] resid;
    logic signed [34:0] scaled;
    logic signed [18:0] n_raw, n_adj, sgn_r, sgn_n;
    logic signed [4:0]  n_clamp;
    logic        [2:0]  qr_d;
    logic signed [15:0] dq, delta, recon_d;
    logic signed [15:0] w_next [4];

    function automatic logic [16:0] recip_f(input logic [3:0] s);
        case (s)
            4'd0:  recip_f = 17'd65536;
            4'd1:  recip_f = 17'd9363;
            4'd2:  recip_f = 17'd3121;
            4'd3:  recip_f = 17'd1457;
            4'd4:  recip_f = 17'd781;
            4'd5:  recip_f = 17'd475;
            4'd6:  recip_f = 17'd311;
            4'd7:  recip_f = 17'd216;
            4'd8:  recip_f = 17'd156;
            4'd9:  recip_f = 17'd117;
            4'd10: recip_f = 17'd90;
            4'd11: recip_f = 17'd71;
            4'd12: recip_f = 17'd57;
            4'd13: recip_f = 17'd47;
            4'd14: recip_f = 17'd39;
            default: recip_f = 17'd32;
        endcase
    endfunction

    // Index is n+8, n in [-8, 8].
    function automatic logic [2:0] quant_f(input logic [4:0] k);
        case (k)
            5'd0, 5'd1, 5'd2: quant_f = 3'd7;
            5'd3, 5'd4:       quant_f = 3'd5;
            5'd5, 5'd6:       quant_f = 3'd3;
            5'd7:             quant_f = 3'd1;
            5'd8, 5'd9:       quant_f = 3'd0;
            5'd10, 5'd11:     quant_f = 3'd2;
            5'd12, 5'd13:     quant_f = 3'd4;
            default:          quant_f = 3'd6;
        endcase
    endfunction

    QOA_ROM u_rom (
        .addr1 (sf_q),
        .addr2 (qr_q),
        .data  (dq)
    );

    always_comb begin
        mac_prod = 32'(hist_q[cnt_q]) * 32'(weights_q[cnt_q]);
        p_d      = $signed(acc_q[28:13]);
        resid    = 17'(sample_q) - 17'(p_d);
        scaled   = 35'(resid) * 35'($signed({1'b0, recip_f(sf_q)}));
        n_raw    = 19'((scaled + 35'sd32768) >>> 16);
        sgn_r    = (resid > 0) ? 19'sd1 : ((resid < 0) ? -19'sd1 : 19'sd0);
        sgn_n    = (n_raw > 0) ? 19'sd1 : ((n_raw < 0) ? -19'sd1 : 19'sd0);
        // Pull a rounded-to-zero result back toward the residual's sign.
        n_adj    = n_raw + sgn_r - sgn_n;
        if (n_adj > 19'sd8)
            n_clamp = 5'sd8;
        else if (n_adj < -19'sd8)
            n_clamp = -5'sd8;
        else
            n_clamp = n_adj[4:0];
        qr_d     = quant_f(n_clamp + 5'sd8);
        delta    = dq >>> 4;
        recon_d  = p_q + dq;
        for (int i = 0; i < 4; i++)
            w_next[i] = weights_q[i] + (hist_q[i][15] ? -delta : delta);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            sf_q     <= 4'd0;
            sel_q    <= 1'b0;
            idx_q    <= 2'd0;
            sample_q <= 16'sd0;
            acc_q    <= 32'sd0;
            cnt_q    <= 2'd0;
            p_q      <= 16'sd0;
            qr_q     <= 3'd0;
            code_q   <= 8'h00;
            valid_q  <= 1'b0;
            recon_q  <= 16'd0;
            busy_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hist_q[i]    <= 16'sd0;
                weights_q[i] <= 16'sd0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_rdy) begin
                        if (spi_in[0]) begin
                            sf_q    <= spi_in[7:4];
                            state_q <= SAMP_HI;
                        end else if (!spi_in[7]) begin
                            sel_q   <= spi_in[1];
                            idx_q   <= spi_in[3:2];
                            state_q <= LOAD_HI;
                        end
                    end
                end
                LOAD_HI: begin
                    if (data_rdy) begin
                        if (sel_q) weights_q[idx_q][15:8] <= spi_in;
                        else       hist_q[idx_q][15:8]    <= spi_in;
                        state_q <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (data_rdy) begin
                        if (sel_q) weights_q[idx_q][7:0] <= spi_in;
                        else       hist_q[idx_q][7:0]    <= spi_in;
                        state_q <= IDLE;
                    end
                end
                SAMP_HI: begin
                    if (data_rdy) begin
                        sample_q[15:8] <= spi_in;
                        state_q        <= SAMP_LO;
                    end
                end
                SAMP_LO: begin
                    if (data_rdy) begin
                        sample_q[7:0] <= spi_in;
                        acc_q         <= 32'sd0;
                        cnt_q         <= 2'd0;
                        busy_q        <= 1'b1;
                        state_q       <= PREDICT;
                    end
                end
                PREDICT: begin
                    acc_q <= acc_q + mac_prod;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_q <= QUANT;
                end
                QUANT: begin
                    p_q     <= p_d;
                    qr_q    <= qr_d;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    for (int i = 0; i < 4; i++) weights_q[i] <= w_next[i];
                    hist_q[0] <= hist_q[1];
                    hist_q[1] <= hist_q[2];
                    hist_q[2] <= hist_q[3];
                    hist_q[3] <= recon_d;
                    recon_q   <= recon_d;
                    code_q    <= {sf_q, qr_q, 1'b1};
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign recon_out  = recon_q;
    assign busy       = busy_q;
endmodule

// File: doc/qoa_encoder.md
# qoa_encoder

Byte-fed QOA slice encoder: the encoding counterpart of the on-chip `qoa_decoder`. It takes a scalefactor index and a 16-bit PCM sample over the same byte command stream. It runs the identical 4-tap LMS predictor, quantizes the residual to a 3-bit index, and emits the exact command byte `qoa_decoder` consumes (`{sf, qr, 1}`). It updates its own history and weights bit-exactly as the decoder does, so encoder and decoder never drift.

## Interface
- No parameters.
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `data_rdy`  in  1  one-cycle strobe: `spi_in` holds a valid byte.
- `spi_in`  in  8  command/data byte.
- `code_out`  out  8  last emitted code byte `{sf_index[3:0], qr_index[2:0], 1'b1}`.
- `code_valid`  out  1  one-cycle pulse when `code_out` is updated.
- `recon_out`  out  16  last reconstructed sample; equals what `qoa_decoder` will produce.
- `busy`  out  1  high while the encode pipeline runs; `data_rdy` is ignored while high.

## Operation
- Reset values:
  - `code_out` = 0x00, `code_valid` = 0, `recon_out` = 0, `busy` = 0.
  - All history[0..3] and weights[0..3] = 0.
  - State = IDLE.
- States: IDLE, LOAD_HI, LOAD_LO, SAMP_HI, SAMP_LO, PREDICT, QUANT, UPDATE.
- IDLE, on `data_rdy`:
  - `spi_in[0]`=1: latch `sf_index`=`spi_in[7:4]`, go to SAMP_HI. Bits 3:1 are ignored.
  - `spi_in[0]`=0, `spi_in[7]`=0: latch `sel`=`spi_in[1]` (1=weights, 0=history) and `idx`=`spi_in[3:2]`, go to LOAD_HI.
  - `spi_in[0]`=0, `spi_in[7]`=1: ignored, stay in IDLE.
- LOAD_HI / LOAD_LO, on `data_rdy`: write the high byte, then the low byte, into the selected register. Return to IDLE after the low byte. The upper byte is written before the lower byte is known; this is intended.
- SAMP_HI / SAMP_LO, on `data_rdy`: assemble the sample high byte then low byte. After the low byte, go to PREDICT.
- PREDICT, 4 cycles: `acc` (32-bit signed, cleared on entry) += `history[i]*weights[i]` for i=0..3, one product per cycle, wrapping at 32 bits.
- QUANT, 1 cycle:
  - `p` = `acc[28:13]` (16-bit).
  - `r` = `sample` − `p`, 17-bit signed.
  - `n` = (`r`*`recip[sf]` + 32768) >>> 16.
  - `n` += sgn(`r`) − sgn(`n`).
  - Clamp `n` to [−8, 8].
  - `qr` = `quant_tab[n+8]` = {7,7,7,5,5,3,3,1,0,0,2,2,4,4,6,6,6}.
  - `recip` = {65536, 9363, 3121, 1457, 781, 475, 311, 216, 156, 117, 90, 71, 57, 47, 39, 32}.
- UPDATE, 1 cycle:
  - `dq` = `QOA_ROM`(`addr1`=`sf`, `addr2`=`qr`). Instantiate the existing ROM; do not duplicate it.
  - `recon` = `p` + `dq`, truncated to 16 bits. No clamp, to match the decoder.
  - `delta` = `dq` >>> 4.
  - `weights[i]` += (`history[i]` < 0 ? −`delta` : `delta`), using the pre-shift history.
  - History shifts: `h0`←`h1`, `h1`←`h2`, `h2`←`h3`, `h3`←`recon`.
  - Register `code_out`, `recon_out`, and pulse `code_valid`. Return to IDLE.
- `busy` = 1 in PREDICT, QUANT, and UPDATE. `data_rdy` in those states is dropped, not queued.
- `data_rdy` is honoured in LOAD_* and SAMP_* with no timeout; a stalled host leaves the block waiting.

## Timing
- Cycle 0 is the cycle where `data_rdy` carries the sample low byte.
  - Cycles 1–4: PREDICT.
  - Cycle 5: QUANT.
  - Cycle 6: UPDATE.
  - Cycle 7: `code_valid`=1 and the new `code_out`/`recon_out` are visible; `busy`=0.
- `busy` is high in cycles 1–6.
- A new command byte is accepted from cycle 7 onward, i.e. back-to-back encodes at most every 10 strobes-worth of time (3 strobes + 7 cycles).
- `code_out`/`recon_out` hold until the next UPDATE.
- `sys_rst` asserted in any state, including mid-PREDICT or between load bytes, immediately forces all reset values. A partial load or encode is discarded.

## Test plan
1. Reset state, cmd 0x01, sample 0x0001 → cycle 7: `code_out`=0x01, `recon_out`=0x0001, weights unchanged (`delta`=0), history={0,0,0,1}.
2. Reset state, cmd 0xF1, sample 0x4000 → `n`=8, `qr`=6, `code_out`=0xFD, `recon_out`=14336, all weights=896.
3. Reset state, cmd 0x11, sample 0xFFF9 → `n`=−1, `qr`=1, `code_out`=0x13, `recon_out`=0xFFFB.
4. Reset state, cmd 0x01, sample 0x7FFF → clamp to 8, `code_out`=0x0D, `recon_out`=7.
5. Load weights[3]=0x2000 (0x0E,0x20,0x00) and history[3]=0x1000 (0x0C,0x10,0x00), then encode 1000 random samples with random sf. Feed each `code_out` into `qoa_decoder` preloaded identically. Decoder `sample` must equal `recon_out` every time.
6. `data_rdy` pulses during cycles 1–6 are ignored and the result equals test 2. `sys_rst` pulsed in cycle 3 → all outputs and registers at reset values, next encode behaves as in test 1.
